// File: rtl/nioslab2_pio_in.sv
// nioslab2_pio_in -- Avalon-MM slave input PIO.
// Samples an external WIDTH-bit bus through a two-stage synchronizer,
// latches selected edges into a sticky edge-capture register and raises a
// maskable interrupt (edge or level sourced).
// Optional feature macro: NIOSLAB2_PIO_IN_BITCLR_EN
//   defined   -> writes to edge_capture clear only the bits written as 1
//   undefined -> any write to edge_capture clears every bit
// Register map (word address): 0 data (RO), 1 direction (reads 0),
//   2 irq_mask (RW), 3 edge_capture (read / write-clear).
module nioslab2_pio_in #(
  parameter int WIDTH     = 4,  // 1..32
  parameter int EDGE_TYPE = 0,  // 0 rising, 1 falling, 2 any
  parameter int IRQ_TYPE  = 0   // 0 edge (edge_capture), 1 level (data)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_irq_src;
  logic [31:0]      w_rd_mux;
  logic             w_wr_mask;
  logic             w_wr_ecap;
  logic             w_unused_wdata;

  assign w_wr_mask = chipselect & ~write_n & (address == 2'd2);
  assign w_wr_ecap = chipselect & ~write_n & (address == 2'd3);

  // Upper write-data bits have no storage behind them.
  assign w_unused_wdata = ^writedata;

  // Synchronizer chain; s2 is the CPU-visible data, s3 is its previous value
  // used only for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Per-bit edge detector selected at elaboration time.
  always_comb begin
    case (EDGE_TYPE)
      0:       w_edge = r_s2 & ~r_s3;
      1:       w_edge = ~r_s2 & r_s3;
      default: w_edge = r_s2 ^ r_s3;
    endcase
  end

  // Bits to clear on a CPU write to edge_capture.
  always_comb begin
`ifdef NIOSLAB2_PIO_IN_BITCLR_EN
    w_clr = w_wr_ecap ? writedata[WIDTH-1:0] : '0;
`else
    w_clr = {WIDTH{w_wr_ecap}};
`endif
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_mask <= '0;
    else if (w_wr_mask) r_mask <= writedata[WIDTH-1:0];
  end

  // Sticky edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ecap <= '0;
    else          r_ecap <= (r_ecap & ~w_clr) | w_edge;
  end

  // Read mux, zero-extended to the 32-bit bus.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_s2;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_ecap;
      default: w_rd_mux = '0;
    endcase
  end

  // Read data registered every cycle regardless of chipselect (latency 1);
  // a same-cycle write is therefore not visible in this read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign readdata = r_readdata;

  generate
    if (IRQ_TYPE == 1) begin : g_level_irq
      assign w_irq_src = r_s2;
    end else begin : g_edge_irq
      assign w_irq_src = r_ecap;
    end
  endgenerate

  assign irq = |(w_irq_src & r_mask);

endmodule

// File: doc/nioslab2_pio_in.md
# nioslab2_pio_in

Avalon-MM slave input PIO: samples a WIDTH-bit external input bus through a two-stage synchronizer, exposes the synchronized value for CPU reads, latches selected edges into an edge-capture register, and raises a maskable interrupt. It is the input-direction counterpart of the team's write-only output PIO. It sits on the Nios II data master's interconnect with its irq routed to the CPU interrupt controller.

## Interface
- WIDTH, 4, input bus width (1..32)
- EDGE_TYPE, 0, captured edge: 0 rising, 1 falling, 2 any
- IRQ_TYPE, 0, 0 = edge (from edge-capture), 1 = level (from synchronized data)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register word select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data, bits above WIDTH always 0
- irq  out  1  active-high interrupt request

## Operation
- Synchronizer: s1 <= in_port; s2 <= s1; s3 <= s2. data = s2.
- Edge detect per bit: rising = s2 & ~s3; falling = ~s2 & s3; any = s2 ^ s3, selected by EDGE_TYPE.
- Register map (word addresses):
  - 0 data: RO, synchronized input; writes ignored.
  - 1 direction: unimplemented, reads 0, writes ignored.
  - 2 irq_mask: RW, WIDTH bits; write when chipselect & ~write_n & address==2.
  - 3 edge_capture: read returns captured bits; write clears (see Configuration).
- Edge capture: bit i sets on detected edge of bit i; holds until cleared by CPU. Set has priority over clear in the same cycle.
- irq: IRQ_TYPE 0: |(edge_capture & irq_mask); IRQ_TYPE 1: |(data & irq_mask). Combinational from registers, no additional latency.
- readdata: registered every clock from address mux, independent of chipselect; zero-extended.
- Reset (reset_n low, asynchronous): s1/s2/s3, irq_mask, edge_capture, readdata all 0; irq 0. Reset mid-capture discards pending edges; first two cycles after release may detect an edge only if in_port differs from 0 (rising edges of inputs held high at release are captured, by design).

## Timing
- in_port change before clk edge k: s1 at k, s2 (data) at k+1, edge_capture bit set at k+2, irq (edge mode, mask set) high after edge k+2.
- Level-mode irq high after edge k+1.
- Read latency 1: address presented on cycle n, readdata valid after edge n+1 (Avalon readLatency = 1).
- Writes take effect at the clock edge where chipselect & ~write_n; irq reflects mask/clear after that same edge.
- Pulses shorter than one clk period may be missed; no glitch guarantee.
- Write during a read to same register: read returns pre-write value captured that cycle.

## Configuration
- NIOSLAB2_PIO_IN_BITCLR_EN defined: write to address 3 clears only bits where writedata[i]=1 (write-1-to-clear); other bits retained.
- Undefined: any write to address 3 clears all edge_capture bits regardless of writedata.
- Set-over-clear priority holds in both modes.

## Test plan
- Reset: assert reset_n=0 with in_port=4'hA -> readdata=0, irq=0; release, read addr 0 -> 4'hA (readdata 32'h0000000A) after 2 cycles of sync.
- Rising edge + irq: EDGE_TYPE=0, mask=4'b0010, in_port 0->4'b0010 -> edge_capture=4'b0010 at k+2, irq=1; read addr 3 -> 32'h2.
- Clear: with edge_capture=4'b0110, write addr 3 data 32'h2 -> BITCLR_EN: 4'b0100; undefined: 4'b0000; irq drops per mask next cycle.
- Simultaneous: rising edge on bit 0 detected in same cycle as clear write of 32'h1 -> bit 0 remains 1.
- Level mode: IRQ_TYPE=1, mask=4'b1000, in_port=4'b1000 -> irq=1 at k+1; in_port=0 -> irq=0 at k+1 without CPU write.
- Read latency/unused: read addr 1 -> 0; write 32'hFFFFFFFF to addr 2 then read -> 32'h0000000F.
